// File: rtl/bidirectional_spi_pkg.sv
// Shared types and helpers for the 3-wire half-duplex SPI initiator/responder pair.
package bidirectional_spi_pkg;

    // Responder frame-handling states.
    typedef enum logic [2:0] {
        S_WAIT_CS = 3'd0,
        S_IDLE    = 3'd1,
        S_CMD     = 3'd2,
        S_WR_DATA = 3'd3,
        S_RD_DATA = 3'd4
    } spi_state_e;

    // Value of the leading R/W bit of a frame.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Number of SCLK bits in one complete frame: R/W + address + data.
    function automatic int frame_len(input int addr_width, input int data_width);
        return 1 + addr_width + data_width;
    endfunction

endpackage

// File: rtl/spi_input_synchronizer.sv
// Brings the asynchronous SPI pins into the fabric clock domain and derives
// single-cycle edge pulses from the synchronized SCLK and CS_N.
module spi_input_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_sdio,
    output logic o_sclk,
    output logic o_cs_n,
    output logic o_sdio,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise
);

    logic [SYNC_STAGES-1:0] r_sclk_q;
    logic [SYNC_STAGES-1:0] r_cs_q;
    logic [SYNC_STAGES-1:0] r_sdio_q;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    // Synchronizer chains plus one delayed copy of SCLK/CS_N for edge detection.
    // CS_N clears to 0 so a select already low at reset release is never seen as a fresh falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_q <= {SYNC_STAGES{1'b0}};
            r_cs_q   <= {SYNC_STAGES{1'b0}};
            r_sdio_q <= {SYNC_STAGES{1'b0}};
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b0;
        end else begin
            r_sclk_q <= {r_sclk_q[SYNC_STAGES-2:0], i_sclk};
            r_cs_q   <= {r_cs_q[SYNC_STAGES-2:0], i_cs_n};
            r_sdio_q <= {r_sdio_q[SYNC_STAGES-2:0], i_sdio};
            r_sclk_d <= r_sclk_q[SYNC_STAGES-1];
            r_cs_d   <= r_cs_q[SYNC_STAGES-1];
        end
    end

    assign o_sclk      = r_sclk_q[SYNC_STAGES-1];
    assign o_cs_n      = r_cs_q[SYNC_STAGES-1];
    assign o_sdio      = r_sdio_q[SYNC_STAGES-1];
    assign o_sclk_rise = r_sclk_q[SYNC_STAGES-1] & ~r_sclk_d;
    assign o_sclk_fall = ~r_sclk_q[SYNC_STAGES-1] & r_sclk_d;
    assign o_cs_fall   = ~r_cs_q[SYNC_STAGES-1] & r_cs_d;
    assign o_cs_rise   = r_cs_q[SYNC_STAGES-1] & ~r_cs_d;

endmodule

// File: rtl/bidirectional_spi_responder.sv
// Target end of a 3-wire half-duplex SPI link: decodes R/W + address frames,
// writes the register bank from SPI or drives bank contents back on SDIO.
module bidirectional_spi_responder
    import bidirectional_spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  fabric_clk,
    input  logic                  reset_n,
    input  logic                  spi_cpol,
    input  logic                  spi_cpha,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    inout  wire                   spi_sdio,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  spi_wr_valid,
    output logic [ADDR_WIDTH-1:0] spi_wr_addr,
    output logic [DATA_WIDTH-1:0] spi_wr_data,
    output logic                  busy,
    output logic                  frame_error
);

    localparam int FRAME_LEN  = frame_len(ADDR_WIDTH, DATA_WIDTH);
    localparam int CMD_LEN    = 1 + ADDR_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_LEN + 1);
    localparam int BANK_DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic                  w_sclk_s;
    logic                  w_cs_n_s;
    logic                  w_sdio_s;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic                  w_unused_sync;

    spi_state_e            r_state;
    spi_state_e            w_state_nx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic [ADDR_WIDTH:0]   r_cmd;
    logic [ADDR_WIDTH:0]   w_cmd_nx;
    logic [ADDR_WIDTH:0]   w_cmd_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nx;
    logic                  r_sdio_oe;
    logic                  w_oe_nx;
    logic                  r_sdio_out;
    logic                  w_sdo_nx;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  w_sample;
    logic                  w_drive;
    logic                  w_commit;
    logic                  w_abort;
    logic [DATA_WIDTH-1:0] r_bank [BANK_DEPTH];

    spi_input_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (fabric_clk),
        .i_rst_n     (reset_n),
        .i_sclk      (spi_sclk),
        .i_cs_n      (spi_cs_n),
        .i_sdio      (spi_sdio),
        .o_sclk      (w_sclk_s),
        .o_cs_n      (w_cs_n_s),
        .o_sdio      (w_sdio_s),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise)
    );

    // The SCLK level and the CS_N rising pulse are not needed: CS_N is acted on as a level.
    assign w_unused_sync = w_sclk_s ^ w_cs_rise;

    // Sample on the rising edge for modes 0/3, on the falling edge for modes 1/2; drive on the other.
    assign w_sample    = (r_cpol ^ r_cpha) ? w_sclk_fall : w_sclk_rise;
    assign w_drive     = (r_cpol ^ r_cpha) ? w_sclk_rise : w_sclk_fall;
    assign w_cmd_shift = {r_cmd[ADDR_WIDTH-1:0], w_sdio_s};

    assign spi_sdio = r_sdio_oe ? r_sdio_out : 1'bz;

    // FSM state register.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT_CS;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state, shift-register and SDIO-drive decisions for the current frame.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cmd_nx   = r_cmd;
        w_data_nx  = r_data;
        w_oe_nx    = r_sdio_oe;
        w_sdo_nx   = r_sdio_out;
        w_commit   = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            S_WAIT_CS: begin
                w_oe_nx = 1'b0;
                if (w_cs_n_s) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_WAIT_CS;
                end
            end
            S_IDLE: begin
                w_oe_nx = 1'b0;
                if (w_cs_fall) begin
                    w_state_nx = S_CMD;
                    w_cnt_nx   = {CNT_W{1'b0}};
                    w_cmd_nx   = {(ADDR_WIDTH + 1){1'b0}};
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_CMD: begin
                if (w_cs_n_s) begin
                    w_abort    = 1'b1;
                    w_oe_nx    = 1'b0;
                    w_state_nx = S_IDLE;
                end else if (w_sample) begin
                    w_cmd_nx = w_cmd_shift;
                    w_cnt_nx = r_cnt + CNT_ONE;
                    if (r_cnt == CNT_CMD_LAST) begin
                        if (w_cmd_shift[ADDR_WIDTH] == RW_WRITE) begin
                            w_state_nx = S_WR_DATA;
                        end else if (w_cmd_shift[ADDR_WIDTH] == RW_READ) begin
                            // Snapshot sees the bank before any host write in this same cycle.
                            w_data_nx  = r_bank[w_cmd_shift[ADDR_WIDTH-1:0]];
                            w_state_nx = S_RD_DATA;
                        end else begin
                            w_state_nx = S_WAIT_CS;
                        end
                    end else begin
                        w_state_nx = S_CMD;
                    end
                end else begin
                    w_state_nx = S_CMD;
                end
            end
            S_WR_DATA: begin
                if (r_cnt == CNT_FRAME) begin
                    // All bits are in, so the write commits even if CS_N has just gone high.
                    w_commit   = 1'b1;
                    w_state_nx = S_WAIT_CS;
                end else if (w_cs_n_s) begin
                    w_abort    = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (w_sample) begin
                    w_data_nx = {r_data[DATA_WIDTH-2:0], w_sdio_s};
                    w_cnt_nx  = r_cnt + CNT_ONE;
                end else begin
                    w_state_nx = S_WR_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_cs_n_s) begin
                    w_oe_nx = 1'b0;
                    if (r_cnt == CNT_FRAME) begin
                        w_state_nx = S_WAIT_CS;
                    end else begin
                        w_abort    = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end else if (w_drive) begin
                    if (r_cnt == CNT_FRAME) begin
                        w_oe_nx    = 1'b0;
                        w_state_nx = S_WAIT_CS;
                    end else begin
                        w_oe_nx   = 1'b1;
                        w_sdo_nx  = r_data[DATA_WIDTH-1];
                        w_data_nx = {r_data[DATA_WIDTH-2:0], 1'b0};
                        w_cnt_nx  = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_state_nx = S_RD_DATA;
                end
            end
            default: begin
                w_oe_nx    = 1'b0;
                w_state_nx = S_WAIT_CS;
            end
        endcase
    end

    // Frame datapath: bit counter, command/data shift registers, SDIO drive, latched mode.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= {CNT_W{1'b0}};
            r_cmd      <= {(ADDR_WIDTH + 1){1'b0}};
            r_data     <= {DATA_WIDTH{1'b0}};
            r_sdio_oe  <= 1'b0;
            r_sdio_out <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_cmd      <= w_cmd_nx;
            r_data     <= w_data_nx;
            r_sdio_oe  <= w_oe_nx;
            r_sdio_out <= w_sdo_nx;
            if (r_state == S_IDLE) begin
                r_cpol <= spi_cpol;
                r_cpha <= spi_cpha;
            end else begin
                r_cpol <= r_cpol;
                r_cpha <= r_cpha;
            end
        end
    end

    // Register bank and host read port; the SPI commit is applied last so it wins an address clash.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                r_bank[i] <= {DATA_WIDTH{1'b0}};
            end
            host_rd_data <= {DATA_WIDTH{1'b0}};
        end else begin
            if (host_wr_en) begin
                r_bank[host_wr_addr] <= host_wr_data;
            end
            if (w_commit) begin
                r_bank[r_cmd[ADDR_WIDTH-1:0]] <= r_data;
            end
            host_rd_data <= r_bank[host_rd_addr];
        end
    end

    // Status and SPI-write notification outputs.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_wr_valid <= 1'b0;
            spi_wr_addr  <= {ADDR_WIDTH{1'b0}};
            spi_wr_data  <= {DATA_WIDTH{1'b0}};
            busy         <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            spi_wr_valid <= w_commit;
            frame_error  <= w_abort;
            busy         <= (w_state_nx != S_IDLE);
            if (w_commit) begin
                spi_wr_addr <= r_cmd[ADDR_WIDTH-1:0];
                spi_wr_data <= r_data;
            end else begin
                spi_wr_addr <= spi_wr_addr;
                spi_wr_data <= spi_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_bidirectional_spi_responder.sv
// Bench for bidirectional_spi_responder: a bit-banged SPI initiator plus a
// register-bank model, driven from a vector table, random frames and corner sequences.
module tb_bidirectional_spi_responder;

    localparam int HALF = 4;   // SCLK half period in fabric clocks (SCLK = fabric_clk/8)

    logic        fabric_clk;
    logic        reset_n;
    logic        spi_cpol, spi_cpha, spi_sclk, spi_cs_n;
    wire         spi_sdio;
    logic        tb_oe, tb_sdo;
    logic        host_wr_en;
    logic [3:0]  host_wr_addr, host_rd_addr;
    logic [15:0] host_wr_data, host_rd_data;
    logic        spi_wr_valid;
    logic [3:0]  spi_wr_addr;
    logic [15:0] spi_wr_data;
    logic        busy, frame_error;

    int          n_vec = 0;
    int          n_err = 0;
    int          wv_cnt = 0;
    int          fe_cnt = 0;
    logic [3:0]  wv_addr;
    logic [15:0] wv_data;
    logic [15:0] m_bank [16];

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic        rw;
        logic [3:0]  addr;
        logic [15:0] data;
        int          n_sclk;
        int          exp_wv;
        logic [15:0] exp_val;
    } vec_t;

    vec_t tbl [9];

    assign spi_sdio = tb_oe ? tb_sdo : 1'bz;

    bidirectional_spi_responder #(
        .ADDR_WIDTH  (4),
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .fabric_clk   (fabric_clk),
        .reset_n      (reset_n),
        .spi_cpol     (spi_cpol),
        .spi_cpha     (spi_cpha),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_sdio     (spi_sdio),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .spi_wr_valid (spi_wr_valid),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data),
        .busy         (busy),
        .frame_error  (frame_error)
    );

    initial fabric_clk = 1'b0;
    always #5 fabric_clk = ~fabric_clk;

    // Count write-commit and frame-error pulses away from the active edge.
    always @(negedge fabric_clk) begin
        if (spi_wr_valid) begin
            wv_cnt  = wv_cnt + 1;
            wv_addr = spi_wr_addr;
            wv_data = spi_wr_data;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge fabric_clk);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(negedge fabric_clk);
        host_wr_en = 1'b0;
        m_bank[a] = d;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge fabric_clk);
        host_rd_addr = a;
        @(negedge fabric_clk);
        d = host_rd_data;
    endtask

    // One frame as a bit-banged initiator; n_sclk SCLK cycles are issued before CS_N rises.
    // For reads the data bits are sampled and the responder's drive window is checked.
    task automatic spi_xfer(input logic cpol, input logic cpha, input logic rw,
                            input logic [3:0] addr, input logic [15:0] wdata, input int n_sclk,
                            output logic [15:0] rdata, output int oe_err);
        logic [20:0] tx;
        int          last_drv;
        logic        exp_oe;
        tx       = {rw, addr, wdata};
        last_drv = rw ? 4 : 20;
        rdata    = 16'h0000;
        oe_err   = 0;
        @(negedge fabric_clk);
        spi_cpol = cpol; spi_cpha = cpha; spi_sclk = cpol;
        repeat (8) @(negedge fabric_clk);
        spi_cs_n = 1'b0;
        if (!cpha) begin tb_oe = 1'b1; tb_sdo = tx[20]; end
        repeat (HALF) @(negedge fabric_clk);
        for (int k = 0; k < n_sclk; k++) begin
            for (int e = 0; e < 2; e++) begin
                // e==0 leading edge, e==1 trailing edge; sample edge is leading when CPHA=0
                if ((e == 0) == (cpha == 1'b0)) begin
                    exp_oe = rw && (k >= 5) && (k <= 20);
                    if (dut.r_sdio_oe !== exp_oe) oe_err++;
                    if (exp_oe) rdata = {rdata[14:0], spi_sdio};
                end else begin
                    if ((k + e) <= last_drv) begin
                        tb_oe = 1'b1; tb_sdo = tx[20 - (k + e)];
                    end else begin
                        tb_oe = 1'b0;
                    end
                end
                spi_sclk = (e == 0) ? ~cpol : cpol;
                if (k == 2 && e == 0) check("busy_mid_frame", busy, 1);
                repeat (HALF) @(negedge fabric_clk);
            end
        end
        spi_cs_n = 1'b1; tb_oe = 1'b0;
        repeat (8) @(negedge fabric_clk);
        if (dut.r_sdio_oe !== 1'b0) oe_err++;
    endtask

    initial begin
        logic [15:0] rd, hv;
        int          oe_err, wv0, fe0, to_flag;
        logic        m_cpol, m_cpha, m_rw;
        logic [3:0]  m_addr;
        logic [15:0] m_data;

        for (int i = 0; i < 16; i++) m_bank[i] = 16'h0000;
        reset_n = 1'b0; spi_cpol = 1'b0; spi_cpha = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1;
        tb_oe = 1'b0; tb_sdo = 1'b0; host_wr_en = 1'b0; host_wr_addr = 4'h0;
        host_wr_data = 16'h0000; host_rd_addr = 4'h0;

        // Table of directed frames: {cpol, cpha, rw, addr, data, sclks, write pulses, bank value after}
        tbl[0] = '{1'b0, 1'b0, 1'b0, 4'h3, 16'hA5C3, 21, 1, 16'hA5C3};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 4'h7, 16'h0000, 21, 0, 16'h1234};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 4'h7, 16'h0000, 21, 0, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 4'h7, 16'h0000, 21, 0, 16'h1234};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 4'h7, 16'h0000, 21, 0, 16'h1234};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 4'hF, 16'h8001, 21, 1, 16'h8001};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 21, 0, 16'h8001};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 16'h0F0F, 21, 1, 16'h0F0F};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 21, 0, 16'h0F0F};

        // Reset state
        repeat (4) @(negedge fabric_clk);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", spi_wr_valid, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_sdio_oe", dut.r_sdio_oe, 0);
        reset_n = 1'b1;
        repeat (8) @(negedge fabric_clk);
        host_read(4'h3, hv);
        check("rst_bank3", hv, 16'h0000);
        check("idle_busy", busy, 0);

        // Directed table
        host_write(4'h7, 16'h1234);
        foreach (tbl[i]) begin
            wv0 = wv_cnt; fe0 = fe_cnt;
            spi_xfer(tbl[i].cpol, tbl[i].cpha, tbl[i].rw, tbl[i].addr, tbl[i].data,
                     tbl[i].n_sclk, rd, oe_err);
            check($sformatf("tbl%0d_wr_pulses", i), wv_cnt - wv0, tbl[i].exp_wv);
            if (tbl[i].rw) begin
                check($sformatf("tbl%0d_read_data", i), rd, tbl[i].exp_val);
            end else begin
                check($sformatf("tbl%0d_wr_addr", i), wv_addr, tbl[i].addr);
                check($sformatf("tbl%0d_wr_data", i), wv_data, tbl[i].data);
                m_bank[tbl[i].addr] = tbl[i].data;
            end
            check($sformatf("tbl%0d_sdio_window", i), oe_err, 0);
            check($sformatf("tbl%0d_frame_error", i), fe_cnt - fe0, 0);
            check($sformatf("tbl%0d_busy_end", i), busy, 0);
            host_read(tbl[i].addr, hv);
            check($sformatf("tbl%0d_bank", i), hv, tbl[i].exp_val);
        end

        // Random frames against the bank model
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) host_write(4'($urandom_range(0, 15)), 16'($urandom));
            m_cpol = 1'($urandom_range(0, 1)); m_cpha = 1'($urandom_range(0, 1));
            m_rw   = 1'($urandom_range(0, 1)); m_addr = 4'($urandom_range(0, 15));
            m_data = 16'($urandom);
            wv0 = wv_cnt;
            spi_xfer(m_cpol, m_cpha, m_rw, m_addr, m_data, 21, rd, oe_err);
            if (m_rw) begin
                check($sformatf("rnd%0d_read_data", n), rd, m_bank[m_addr]);
                check($sformatf("rnd%0d_wr_pulses", n), wv_cnt - wv0, 0);
            end else begin
                m_bank[m_addr] = m_data;
                check($sformatf("rnd%0d_wr_pulses", n), wv_cnt - wv0, 1);
                check($sformatf("rnd%0d_wr_data", n), {wv_addr, wv_data}, {m_addr, m_data});
            end
            check($sformatf("rnd%0d_sdio_window", n), oe_err, 0);
            m_addr = 4'($urandom_range(0, 15));
            host_read(m_addr, hv);
            check($sformatf("rnd%0d_bank", n), hv, m_bank[m_addr]);
        end

        // Truncated write: CS_N rises after 9 of 21 bits
        host_write(4'h2, 16'h2222);
        wv0 = wv_cnt; fe0 = fe_cnt;
        spi_xfer(1'b0, 1'b0, 1'b0, 4'h2, 16'hDEAD, 9, rd, oe_err);
        check("trunc_frame_error", fe_cnt - fe0, 1);
        check("trunc_wr_pulses", wv_cnt - wv0, 0);
        check("trunc_busy", busy, 0);
        host_read(4'h2, hv);
        check("trunc_bank2", hv, 16'h2222);
        spi_xfer(1'b0, 1'b0, 1'b0, 4'h2, 16'h5A5A, 21, rd, oe_err);
        check("after_trunc_wr", {wv_cnt - wv0, 12'h0, wv_addr, wv_data}, {32'd1, 12'h0, 4'h2, 16'h5A5A});
        m_bank[2] = 16'h5A5A;

        // Host write 0x0001 held until the SPI commit of 0xBEEF to the same address
        @(negedge fabric_clk);
        host_wr_en = 1'b1; host_wr_addr = 4'h5; host_wr_data = 16'h0001;
        wv0 = wv_cnt; to_flag = 0;
        fork
            spi_xfer(1'b0, 1'b0, 1'b0, 4'h5, 16'hBEEF, 21, rd, oe_err);
            begin
                int c;
                c = 0;
                while (!spi_wr_valid && c < 600) begin @(negedge fabric_clk); c++; end
                host_wr_en = 1'b0;
                to_flag = (c >= 600) ? 1 : 0;
            end
        join
        check("collide_commit_seen", to_flag, 0);
        check("collide_wr_pulses", wv_cnt - wv0, 1);
        host_read(4'h5, hv);
        check("collide_bank5", hv, 16'hBEEF);

        // Reset pulsed while CS_N is low mid-frame
        wv0 = wv_cnt; fe0 = fe_cnt;
        fork
            spi_xfer(1'b0, 1'b0, 1'b0, 4'h9, 16'h1111, 21, rd, oe_err);
            begin
                repeat (60) @(negedge fabric_clk);
                reset_n = 1'b0;
                repeat (3) @(negedge fabric_clk);
                reset_n = 1'b1;
            end
        join
        for (int i = 0; i < 16; i++) m_bank[i] = 16'h0000;
        check("midrst_wr_pulses", wv_cnt - wv0, 0);
        check("midrst_frame_error", fe_cnt - fe0, 0);
        host_read(4'h7, hv);
        check("midrst_bank_cleared", hv, 16'h0000);
        spi_xfer(1'b0, 1'b0, 1'b0, 4'h9, 16'h2468, 21, rd, oe_err);
        check("midrst_next_frame", {wv_cnt - wv0, 12'h0, wv_addr, wv_data}, {32'd1, 12'h0, 4'h9, 16'h2468});

        // Read with 30 SCLK cycles: 16 data bits then released
        host_write(4'h4, 16'hFFFF);
        fe0 = fe_cnt;
        spi_xfer(1'b0, 1'b0, 1'b1, 4'h4, 16'h0000, 30, rd, oe_err);
        check("long_read_data", rd, 16'hFFFF);
        check("long_read_sdio_window", oe_err, 0);
        check("long_read_frame_error", fe_cnt - fe0, 0);
        check("long_read_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
